// File: rtl/percept_sched.sv
// percept_sched: round-robin arbiter and sequencer for one shared bit-serial percept datapath.
// Optional PERCEPT_SCHED_ABORT_EN: a granted requester may abort by dropping req before RES.
module percept_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             in,
  output logic             shift,
  output logic             mul,
  output logic             acc,
  output logic             shift_res,
  input  logic             out_res,
  output logic             res_bit,
  output logic             res_vld
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(2*WIDTH);
  localparam int OW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_ACC, S_RES, S_DONE
  } state_t;

  state_t state, nxt;
  logic [PW-1:0] ptr, g, win, g_inc, idx;
  logic [BW-1:0] bcnt;
  logic [OW-1:0] ocnt;
  logic b_op_end, b_res_end, o_last, abort;
  int j;

  assign b_op_end  = bcnt == BW'(WIDTH-1);
  assign b_res_end = bcnt == BW'(2*WIDTH-1);
  assign o_last    = ocnt == OW'(N_IN-1);
  assign g_inc     = (g == PW'(N_REQ-1)) ? '0 : g + 1'b1;

  assign in      = shift & din[g];
  assign res_bit = res_vld & out_res;

`ifdef PERCEPT_SCHED_ABORT_EN
  assign abort = (state == S_LOAD || state == S_MUL ||
                  state == S_ACC) && !req[g];
`else
  assign abort = 1'b0;
`endif

  // Scan downward so the smallest offset from ptr is the last writer.
  always_comb begin
    win = ptr;
    j   = 0;
    idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      j   = (int'(ptr) + i) % N_REQ;
      idx = PW'(j);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (|req) nxt = S_LOAD;
      S_LOAD:  if (b_op_end && o_last) nxt = S_MUL;
      S_MUL:   if (b_op_end) nxt = S_ACC;
      S_ACC:   nxt = o_last ? S_RES : S_MUL;
      S_RES:   if (b_res_end) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      g         <= '0;
      bcnt      <= '0;
      ocnt      <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      shift     <= 1'b0;
      mul       <= 1'b0;
      acc       <= 1'b0;
      shift_res <= 1'b0;
      res_vld   <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= nxt != S_IDLE;
      shift     <= nxt == S_LOAD;
      mul       <= nxt == S_MUL;
      acc       <= nxt == S_ACC;
      shift_res <= nxt == S_RES;
      res_vld   <= nxt == S_RES;
      done      <= (nxt == S_DONE) ? gnt : '0;

      if (state == S_IDLE && nxt == S_LOAD) begin
        g   <= win;
        gnt <= N_REQ'(1) << win;
      end else if (nxt == S_IDLE) begin
        gnt <= '0;
      end

      if (state == S_DONE || abort) ptr <= g_inc;

      // LOAD reuses the bit counter per operand; ocnt spans LOAD and MUL/ACC.
      if (nxt != state || (state == S_LOAD && b_op_end))
        bcnt <= '0;
      else if (state != S_IDLE)
        bcnt <= bcnt + 1'b1;

      if (nxt == S_IDLE || nxt == S_RES ||
          (state == S_LOAD && nxt == S_MUL))
        ocnt <= '0;
      else if ((state == S_LOAD && b_op_end) || state == S_ACC)
        ocnt <= ocnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_percept_sched.sv
// tb_percept_sched: scoreboard bench for percept_sched.
// Stimulus queues expected jobs; a negedge monitor checks grants, strobes and completions.
module tb_percept_sched;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NI = 4;
  localparam int JL = NI*W + NI*(W+1) + 2*W + 1;
`ifdef PERCEPT_SCHED_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] din = '0;
  logic [N-1:0] gnt, done;
  logic busy, in, shift, mul, acc, shift_res;
  logic out_res = 1'b0;
  logic res_bit, res_vld;

  percept_sched #(.N_REQ(N), .WIDTH(W), .N_IN(NI)) dut (
    .clk(clk), .nRst(nRst), .req(req), .din(din),
    .gnt(gnt), .done(done), .busy(busy), .in(in),
    .shift(shift), .mul(mul), .acc(acc),
    .shift_res(shift_res), .out_res(out_res),
    .res_bit(res_bit), .res_vld(res_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    din     = 4'($urandom);
    out_res = 1'($urandom);
  end

  typedef struct {
    int idx;
    int start;
    int abort_at;
  } job_t;
  job_t sb[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor
  logic [N-1:0] pg = '0;
  int ns, nm, na, nr, nex, nin, nrb;
  always @(negedge clk) begin
    if (!nRst) begin
      pg = '0;
    end else begin
      if (gnt != 0 && pg == 0) begin
        if (sb.size() == 0) chk("spurious_gnt", int'(gnt), 0);
        else begin
          chk("gnt_idx", int'(gnt), 1 << sb[0].idx);
          chk("gnt_start", cyc, sb[0].start);
        end
        ns = 0; nm = 0; na = 0; nr = 0;
        nex = 0; nin = 0; nrb = 0;
      end
      if (gnt != 0) begin
        ns += int'(shift);
        nm += int'(mul);
        na += int'(acc);
        nr += int'(shift_res);
        if (int'(shift) + int'(mul) + int'(acc) + int'(shift_res) > 1) nex++;
        if (in !== (shift & |(din & gnt))) nin++;
        if (res_bit !== (res_vld & out_res)) nrb++;
        if (res_vld !== shift_res) nrb++;
      end else if (in !== 1'b0) begin
        nin++;
      end
      if (done != 0) begin
        if (sb.size() == 0) chk("spurious_done", int'(done), 0);
        else if (sb[0].abort_at != 0) chk("done_on_abort", int'(done), 0);
        else begin
          chk("done_idx", int'(done), 1 << sb[0].idx);
          chk("done_cycle", cyc, sb[0].start + JL - 1);
          chk("shift_cnt", ns, NI*W);
          chk("mul_cnt", nm, NI*W);
          chk("acc_cnt", na, NI);
          chk("res_cnt", nr, 2*W);
          chk("strobe_excl", nex, 0);
          chk("in_mux", nin, 0);
          chk("res_mux", nrb, 0);
        end
      end
      if (gnt == 0 && pg != 0) begin
        if (sb.size() == 0) chk("spurious_gnt_end", int'(pg), 0);
        else begin
          chk("gnt_end", cyc, sb[0].start +
              (sb[0].abort_at != 0 ? sb[0].abort_at : JL));
          chk("busy_end", int'(busy), 0);
          chk("strobes_end", int'({shift, mul, acc, shift_res}), 0);
          void'(sb.pop_front());
        end
      end
      pg = gnt;
    end
  end

  task automatic push(input int idx, input int start, input int ab);
    job_t e;
    e.idx = idx;
    e.start = start;
    e.abort_at = ab;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, sb.size(), 0);
  endtask

  // One job held for its full length, then req dropped.
  task automatic one_job(input logic [N-1:0] r, input int idx, input string nm);
    @(negedge clk);
    req = r;
    push(idx, cyc + 1, 0);
    repeat (JL) @(negedge clk);
    req = '0;
    wait_empty(nm);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 nRst = 1'b0;
    @(negedge clk);
    #2 nRst = 1'b1;
  endtask

  int c0, s2;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({in, shift, mul, acc, shift_res, res_bit, res_vld}), 0);
    #2 nRst = 1'b1;

    one_job(4'b0001, 0, "single_job");

    // Fairness from a fresh pointer
    pulse_reset();
    @(negedge clk);
    req = 4'b1111;
    c0 = cyc;
    for (int k = 0; k < 5; k++) push(k % N, c0 + 1 + 86*k, 0);
    repeat (86*4 + 85) @(negedge clk);
    req = '0;
    wait_empty("fairness");

    // ptr is 1 here; serve 3, then 1001 must pick 0
    one_job(4'b1000, 3, "serve_3");
    one_job(4'b1001, 0, "wrap_to_0");

    // Reset in the middle of MUL
    @(negedge clk);
    req = 4'b0010;
    c0 = cyc;
    push(1, c0 + 1, 0);
    repeat (40) @(negedge clk);
    chk("mul_before_rst", int'(mul), 1);
    #2 nRst = 1'b0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_outs",
        int'({in, shift, mul, acc, shift_res, res_bit, res_vld, done}), 0);
    sb.delete();
    req = '0;
    @(negedge clk);
    #2 nRst = 1'b1;
    one_job(4'b0100, 2, "after_rst");

    // Drop req[1] at cycle 50; ptr is 3 so requester 1 wins first
    @(negedge clk);
    req = 4'b0010;
    c0 = cyc;
    push(1, c0 + 1, ABORT ? 50 : 0);
    repeat (50) @(negedge clk);
    req = 4'b0101;
    s2 = ABORT ? c0 + 52 : c0 + 87;
    push(2, s2, 0);
    repeat (s2 + 84 - (c0 + 50)) @(negedge clk);
    req = '0;
    wait_empty("abort_seq");

    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
